// File: rtl/charbuf_pkg.sv
// Shared types and logical-to-physical address mapping for the scrolling character buffer.
package charbuf_pkg;

  typedef enum logic [1:0] {
    SCROLL_UP    = 2'b00,
    CLEAR_SCREEN = 2'b01,
    CLEAR_EOL    = 2'b10,
    CLEAR_EOS    = 2'b11
  } cmd_e;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  // row must be < rows and top < rows, so one conditional subtract wraps the sum.
  function automatic logic [31:0] phys_addr(input logic [31:0] row, input logic [31:0] col,
                                            input logic [31:0] top, input logic [31:0] rows,
                                            input logic [31:0] cols);
    logic [31:0] prow;
    prow = row + top;
    if (prow >= rows) prow = prow - rows;
    return prow * cols + col;
  endfunction

endpackage

// File: rtl/char_buffer_ram.sv
// Simple dual-port character RAM: one write port, one registered read port.
// Cells power up holding FILL_CHAR; the read register returns FILL_CHAR when rd_en is low.
module char_buffer_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH = 1920,
  parameter int ADDR_W = 11,
  parameter logic [DATA_W-1:0] FILL_CHAR = DATA_W'(8'h20)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH] = '{default: FILL_CHAR};

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Non-blocking read of mem gives read-before-write on a same-address collision.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      rdata <= FILL_CHAR;
    else if (rd_en) rdata <= mem[raddr];
    else            rdata <= FILL_CHAR;
  end

endmodule

// File: rtl/char_buffer_scroll.sv
// Terminal character store with circular-row hardware scrolling and a FILL_CHAR clear engine.
// Define CHARBUF_CLEAR_EOL_EN to enable CLEAR_EOL/CLEAR_EOS; otherwise those commands are no-ops.
//
// state | meaning
// IDLE  | accepting writes (priority) and commands
// CLEAR | writing FILL_CHAR to clr_addr..clr_end, one cell per cycle, wrapping at the last cell
module char_buffer_scroll
  import charbuf_pkg::*;
#(
  parameter int COLS = 80,
  parameter int ROWS = 24,
  parameter int DATA_W = 8,
  parameter logic [DATA_W-1:0] FILL_CHAR = DATA_W'(8'h20),
  localparam int ROW_W = $clog2(ROWS),
  localparam int COL_W = $clog2(COLS),
  localparam int ADDR_W = $clog2(ROWS*COLS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ROW_W-1:0]  wr_row,
  input  logic [COL_W-1:0]  wr_col,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd,
  input  logic [ROW_W-1:0]  cmd_row,
  input  logic [COL_W-1:0]  cmd_col,
  input  logic [ROW_W-1:0]  rd_row,
  input  logic [COL_W-1:0]  rd_col,
  output logic [DATA_W-1:0] rd_data,
  output logic [ROW_W-1:0]  top_row,
  output logic              busy
);

  localparam int CELLS = ROWS * COLS;
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(COLS - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(CELLS - 1);

  state_e            state, state_nxt;
  logic [ROW_W-1:0]  top_nxt, top_inc;
  logic [ADDR_W-1:0] clr_addr, clr_end, clr_addr_nxt, clr_end_nxt;
  logic [ADDR_W-1:0] wr_addr, rd_addr, ram_waddr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_we, wr_ok, rd_ok;

  assign wr_ok   = (wr_row <= ROW_LAST) && (wr_col <= COL_LAST);
  assign rd_ok   = (rd_row <= ROW_LAST) && (rd_col <= COL_LAST);
  assign top_inc = (top_row == ROW_LAST) ? '0 : top_row + 1'b1;
  assign wr_addr = ADDR_W'(phys_addr(32'(wr_row), 32'(wr_col), 32'(top_row), ROWS, COLS));
  assign rd_addr = ADDR_W'(phys_addr(32'(rd_row), 32'(rd_col), 32'(top_row), ROWS, COLS));

  assign wr_ready  = (state == IDLE);
  assign cmd_ready = (state == IDLE) && !wr_valid;
  assign busy      = (state == CLEAR);

`ifdef CHARBUF_CLEAR_EOL_EN
  logic              cmd_ok;
  logic [ADDR_W-1:0] cmd_start;
  assign cmd_ok    = (cmd_row <= ROW_LAST) && (cmd_col <= COL_LAST);
  assign cmd_start = ADDR_W'(phys_addr(32'(cmd_row), 32'(cmd_col), 32'(top_row), ROWS, COLS));
`else
  logic unused_cmd_pos;
  assign unused_cmd_pos = ^{cmd_row, cmd_col};
`endif

  always_comb begin
    state_nxt    = state;
    top_nxt      = top_row;
    clr_addr_nxt = clr_addr;
    clr_end_nxt  = clr_end;
    ram_we       = 1'b0;
    ram_waddr    = wr_addr;
    ram_wdata    = wr_data;
    case (state)
      IDLE: begin
        if (wr_valid) begin
          ram_we = wr_ok;
        end else if (cmd_valid) begin
          case (cmd_e'(cmd))
            // The new logical last row is the physical row that was logical row 0.
            SCROLL_UP: begin
              top_nxt      = top_inc;
              clr_addr_nxt = ADDR_W'(phys_addr(ROWS - 1, 0, 32'(top_inc), ROWS, COLS));
              clr_end_nxt  = ADDR_W'(phys_addr(ROWS - 1, COLS - 1, 32'(top_inc), ROWS, COLS));
              state_nxt    = CLEAR;
            end
            CLEAR_SCREEN: begin
              top_nxt      = '0;
              clr_addr_nxt = '0;
              clr_end_nxt  = ADDR_LAST;
              state_nxt    = CLEAR;
            end
`ifdef CHARBUF_CLEAR_EOL_EN
            CLEAR_EOL: begin
              if (cmd_ok) begin
                clr_addr_nxt = cmd_start;
                clr_end_nxt  = ADDR_W'(phys_addr(32'(cmd_row), COLS - 1, 32'(top_row), ROWS, COLS));
                state_nxt    = CLEAR;
              end
            end
            CLEAR_EOS: begin
              if (cmd_ok) begin
                clr_addr_nxt = cmd_start;
                clr_end_nxt  = ADDR_W'(phys_addr(ROWS - 1, COLS - 1, 32'(top_row), ROWS, COLS));
                state_nxt    = CLEAR;
              end
            end
`endif
            default: ;
          endcase
        end
      end
      CLEAR: begin
        ram_we    = 1'b1;
        ram_waddr = clr_addr;
        ram_wdata = FILL_CHAR;
        if (clr_addr == clr_end) state_nxt = IDLE;
        else clr_addr_nxt = (clr_addr == ADDR_LAST) ? '0 : clr_addr + 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      top_row  <= '0;
      clr_addr <= '0;
      clr_end  <= '0;
    end else begin
      state    <= state_nxt;
      top_row  <= top_nxt;
      clr_addr <= clr_addr_nxt;
      clr_end  <= clr_end_nxt;
    end
  end

  char_buffer_ram #(
    .DATA_W    (DATA_W),
    .DEPTH     (CELLS),
    .ADDR_W    (ADDR_W),
    .FILL_CHAR (FILL_CHAR)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .rd_en (rd_ok),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_char_buffer_scroll.sv
// Directed self-checking bench for char_buffer_scroll against a logical-screen model.
// Follows CHARBUF_CLEAR_EOL_EN to pick the expected CLEAR_EOL/EOS behaviour.
module tb_char_buffer_scroll;
  localparam int COLS = 80;
  localparam int ROWS = 24;
  localparam logic [7:0] FILL = 8'h20;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_valid, wr_ready, cmd_valid, cmd_ready, busy;
  logic [4:0] wr_row, cmd_row, rd_row, top_row;
  logic [6:0] wr_col, cmd_col, rd_col;
  logic [7:0] wr_data, rd_data;
  logic [1:0] cmd;

  logic [7:0] scr [ROWS][COLS];
  int         mtop;
  logic [7:0] exp_q [$];
  int         n_cmp = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  char_buffer_scroll dut (
    .clk(clk), .reset(reset),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd), .cmd_row(cmd_row), .cmd_col(cmd_col),
    .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data), .top_row(top_row), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_cmp++;
    assert (obs === req) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] mexp(input int r, input int c);
    if (r >= ROWS || c >= COLS) return FILL;
    return scr[r][c];
  endfunction

  task automatic rd(input string tag, input int r, input int c);
    rd_row = 5'(r);
    rd_col = 7'(c);
    exp_q.push_back(mexp(r, c));
    tick();
    chk(tag, 32'(rd_data), 32'(exp_q.pop_front()));
  endtask

  task automatic wr(input int r, input int c, input logic [7:0] d);
    wr_valid = 1'b1;
    wr_row = 5'(r);
    wr_col = 7'(c);
    wr_data = d;
    #1;
    chk("wr_ready", 32'(wr_ready), 1);
    tick();
    wr_valid = 1'b0;
    if (r < ROWS && c < COLS) scr[r][c] = d;
  endtask

  task automatic issue(input logic [1:0] c, input int r, input int col);
    cmd_valid = 1'b1;
    cmd = c;
    cmd_row = 5'(r);
    cmd_col = 7'(col);
    #1;
    chk("cmd_ready", 32'(cmd_ready), 1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic busy_len(input string tag, input int req);
    int n = 0;
    while (busy === 1'b1 && n < 5000) begin
      n++;
      tick();
    end
    chk(tag, 32'(n), 32'(req));
  endtask

  task automatic m_scroll();
    for (int r = 0; r < ROWS - 1; r++) scr[r] = scr[r + 1];
    for (int c = 0; c < COLS; c++) scr[ROWS - 1][c] = FILL;
    mtop = (mtop + 1) % ROWS;
  endtask

  task automatic m_clear_from(input int r0, input int c0, input bit to_end);
    for (int r = r0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if ((r == r0 && c >= c0) || (to_end && r > r0)) scr[r][c] = FILL;
  endtask

  initial begin
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) scr[r][c] = FILL;
    mtop = 0;
    reset = 1'b1;
    wr_valid = 1'b0; wr_row = '0; wr_col = '0; wr_data = '0;
    cmd_valid = 1'b0; cmd = '0; cmd_row = '0; cmd_col = '0;
    rd_row = 5'd31; rd_col = '0;
    repeat (2) tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_top", 32'(top_row), 0);
    chk("rst_wr_ready", 32'(wr_ready), 1);
    chk("rst_cmd_ready", 32'(cmd_ready), 1);
    chk("rst_rd_data", 32'(rd_data), 32'(FILL));
    reset = 1'b0;
    tick();

    // 1: basic write/read, out-of-range reads and writes, read-before-write collision
    wr(0, 0, "A");
    rd("rd_0_0", 0, 0);
    rd("rd_row24", 24, 0);
    rd("rd_col80", 0, 80);
    wr(24, 0, "X");
    rd("oob_wr_no_alias", 0, 0);
    wr_valid = 1'b1; wr_row = 5'd2; wr_col = 7'd2; wr_data = "Z";
    rd_row = 5'd2; rd_col = 7'd2;
    exp_q.push_back(mexp(2, 2));
    tick();
    wr_valid = 1'b0;
    scr[2][2] = "Z";
    chk("rd_before_wr", 32'(rd_data), 32'(exp_q.pop_front()));
    rd("rd_after_wr", 2, 2);

    // 2: fill row 1 with 'B' and scroll once
    for (int c = 0; c < COLS; c++) wr(1, c, "B");
    issue(2'b00, 0, 0);
    m_scroll();
    chk("scroll_top", 32'(top_row), 32'(mtop));
    busy_len("scroll_busy", COLS);
    rd("scr_0_5", 0, 5);
    rd("scr_0_0", 0, 0);
    rd("scr_1_2", 1, 2);
    rd("scr_23_0", 23, 0);
    rd("scr_23_79", 23, 79);

    // 3: scroll until top_row wraps, tracking a marker through each step
    for (int i = 0; i < ROWS - 1; i++) begin
      wr(ROWS - 1, 1, 8'(8'h61 + i));
      issue(2'b00, 0, 0);
      m_scroll();
      chk("wrap_top", 32'(top_row), 32'(mtop));
      busy_len("wrap_busy", COLS);
      rd("wrap_mark", ROWS - 2, 1);
      rd("wrap_clr", ROWS - 1, 1);
    end
    chk("wrap_top_zero", 32'(top_row), 0);
    rd("wrap_old_B", 0, 5);

    // 4: write and command in the same cycle
    wr_valid = 1'b1; wr_row = 5'd4; wr_col = 7'd4; wr_data = "W";
    cmd_valid = 1'b1; cmd = 2'b00;
    #1;
    chk("arb_cmd_ready0", 32'(cmd_ready), 0);
    chk("arb_wr_ready1", 32'(wr_ready), 1);
    tick();
    scr[4][4] = "W";
    wr_valid = 1'b0;
    #1;
    chk("arb_cmd_ready1", 32'(cmd_ready), 1);
    chk("arb_top_hold", 32'(top_row), 32'(mtop));
    tick();
    cmd_valid = 1'b0;
    m_scroll();
    chk("arb_top", 32'(top_row), 32'(mtop));
    busy_len("arb_busy", COLS);
    rd("arb_rd", 3, 4);

    // 5: full clear, then reset in the middle of a second clear
    issue(2'b01, 0, 0);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) scr[r][c] = FILL;
    mtop = 0;
    chk("cs_top", 32'(top_row), 0);
    busy_len("cs_busy", ROWS * COLS);
    rd("cs_rd", 3, 4);
    wr(0, 10, "x");
    wr(1, 19, "y");
    wr(1, 20, "u");
    wr(1, 70, "z");
    issue(2'b01, 0, 0);
    repeat (100) tick();
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_top", 32'(top_row), 0);
    chk("mid_rst_rd_data", 32'(rd_data), 32'(FILL));
    tick();
    reset = 1'b0;
    tick();
    scr[0][10] = FILL;
    scr[1][19] = FILL;
    rd("part_cell10", 0, 10);
    rd("part_cell99", 1, 19);
    rd("part_cell100", 1, 20);
    rd("part_cell150", 1, 70);

    // 6: CLEAR_EOL / CLEAR_EOS, with EOS wrapping around the end of physical memory
    repeat (5) begin
      issue(2'b00, 0, 0);
      m_scroll();
      busy_len("pre6_busy", COLS);
    end
    chk("pre6_top", 32'(top_row), 5);
    wr(3, 69, "P");
    wr(3, 70, "Q");
    wr(3, 79, "R");
    issue(2'b10, 3, 70);
`ifdef CHARBUF_CLEAR_EOL_EN
    m_clear_from(3, 70, 1'b0);
    busy_len("eol_busy", COLS - 70);
`else
    busy_len("eol_busy", 0);
`endif
    rd("eol_c69", 3, 69);
    rd("eol_c70", 3, 70);
    rd("eol_c79", 3, 79);
    wr(10, 74, "S");
    wr(10, 75, "T");
    wr(19, 0, "U");
    wr(23, 79, "V");
    issue(2'b11, 10, 75);
`ifdef CHARBUF_CLEAR_EOL_EN
    m_clear_from(10, 75, 1'b1);
    busy_len("eos_busy", (COLS - 75) + (ROWS - 1 - 10) * COLS);
`else
    busy_len("eos_busy", 0);
`endif
    rd("eos_10_74", 10, 74);
    rd("eos_10_75", 10, 75);
    rd("eos_19_0", 19, 0);
    rd("eos_23_79", 23, 79);
    rd("eos_3_69", 3, 69);
    issue(2'b10, 24, 0);
    busy_len("eol_oob_busy", 0);
    rd("eol_oob_rd", 3, 69);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
